// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: button/switch command entry, ALU handshake and result hold; define ALU_SELF_CHECK_EN for the result self-check
module alu_cmd_seq #(
  parameter int DEB_CYCLES = 16,
  parameter int TO_CYCLES  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_next,
  input  logic       btn_clr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  output logic       alu_valid,
  input  logic       alu_ready,
  input  logic [4:0] alu_out,
  input  logic [3:0] alu_flags,
  output logic [4:0] res,
  output logic [3:0] flags,
  output logic [2:0] phase,
  output logic       timeout,
  output logic       mismatch
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TO_CYCLES + 1);
  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    SHOW   = 3'd5
  } state_t;
  state_t state;
  logic [TW-1:0] to_cnt;
  logic [1:0] raw, ev;
  logic nxt, clr;
  assign raw = {btn_clr, btn_next};
  assign nxt = ev[0];
  assign clr = ev[1];
  assign phase = state;
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [1:0] sy;
    logic lvl, lvl_q;
    logic [DW-1:0] cnt;
    // the level flips only after DEB_CYCLES consecutive samples that disagree with it
    always_ff @(posedge clk)
      if (!rst_n) begin
        sy <= '0;
        lvl <= 1'b0;
        lvl_q <= 1'b0;
        cnt <= '0;
      end else begin
        sy <= {sy[0], raw[i]};
        lvl_q <= lvl;
        if (sy[1] == lvl) cnt <= '0;
        else if (cnt == DW'(DEB_CYCLES - 1)) begin
          lvl <= sy[1];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    assign ev[i] = lvl & ~lvl_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= GET_A;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      alu_valid <= 1'b0;
      res <= '0;
      flags <= '0;
      timeout <= 1'b0;
      to_cnt <= '0;
    end else if (clr) begin
      state <= GET_A;
      res <= '0;
      flags <= '0;
      alu_valid <= 1'b0;
      timeout <= 1'b0;
    end else
      case (state)
        GET_A: if (nxt) begin
          alu_a <= sw;
          state <= GET_B;
        end
        GET_B: if (nxt) begin
          alu_b <= sw;
          state <= GET_OP;
        end
        GET_OP: if (nxt) begin
          alu_sel <= sw[2:0];
          alu_valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          to_cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (alu_ready) begin
          res <= alu_out;
          flags <= alu_flags;
          alu_valid <= 1'b0;
          timeout <= 1'b0;
          state <= SHOW;
        end else if (to_cnt == TW'(TO_CYCLES - 1)) begin
          alu_valid <= 1'b0;
          timeout <= 1'b1;
          state <= SHOW;
        end else to_cnt <= to_cnt + 1'b1;
        SHOW: if (nxt) state <= GET_A;
        default: state <= GET_A;
      endcase
`ifdef ALU_SELF_CHECK_EN
  logic [4:0] exp_res;
  logic cap;
  assign cap = state == WAIT && alu_ready && !clr;
  always_comb begin
    exp_res = '0;
    case (alu_sel)
      3'd0: exp_res = 5'(alu_a) + 5'(alu_b);
      3'd1: exp_res = 5'(alu_a) + (~5'(alu_b) + 5'd1);
      3'd2: exp_res = {1'b0, ~alu_a};
      3'd3: exp_res = {1'b0, alu_a & alu_b};
      3'd4: exp_res = {1'b0, alu_a | alu_b};
      3'd5: exp_res = {1'b0, alu_a ^ alu_b};
      3'd6: exp_res = {4'b0, $signed(alu_a) < $signed(alu_b)};
      3'd7: exp_res = {4'b0, alu_a == alu_b};
      default: exp_res = '0;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n || clr) mismatch <= 1'b0;
    else if (cap && alu_out != exp_res) mismatch <= 1'b1;
`else
  assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed and randomized command entry checked against a per-command behavioural model
module tb_alu_cmd_seq;
  localparam int DEB = 4;
  localparam int TO = 20;
`ifdef ALU_SELF_CHECK_EN
  localparam bit SELF = 1'b1;
`else
  localparam bit SELF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic btn_next = 1'b0, btn_clr = 1'b0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic alu_valid;
  logic alu_ready = 1'b0;
  logic [4:0] alu_out = '0;
  logic [3:0] alu_flags = '0;
  logic [4:0] res;
  logic [3:0] flags;
  logic [2:0] phase;
  logic timeout, mismatch;
  alu_cmd_seq #(.DEB_CYCLES(DEB), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_next(btn_next), .btn_clr(btn_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .alu_out(alu_out), .alu_flags(alu_flags),
    .res(res), .flags(flags), .phase(phase), .timeout(timeout), .mismatch(mismatch)
  );
  always #5 clk = ~clk;
  int n_pass = 0, n_chk = 0;
  int m_phase;
  logic [3:0] m_a, m_b, m_flags;
  logic [2:0] m_sel;
  logic [4:0] m_res;
  logic m_valid, m_to, m_mm;
  function automatic logic [4:0] ref_alu(input int a, input int b, input int s);
    int sa, sb;
    sa = a >= 8 ? a - 16 : a;
    sb = b >= 8 ? b - 16 : b;
    case (s)
      0: return 5'((a + b) & 31);
      1: return 5'((a - b + 32) & 31);
      2: return 5'(15 - a);
      3: return 5'(a & b);
      4: return 5'(a | b);
      5: return 5'(a ^ b);
      6: return 5'(sa < sb ? 1 : 0);
      default: return 5'(a == b ? 1 : 0);
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic chk_all();
    chk("phase", 32'(phase), 32'(m_phase));
    chk("alu_valid", 32'(alu_valid), 32'(m_valid));
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    chk("alu_sel", 32'(alu_sel), 32'(m_sel));
    chk("res", 32'(res), 32'(m_res));
    chk("flags", 32'(flags), 32'(m_flags));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("mismatch", 32'(mismatch), 32'(m_mm));
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic rel();
    btn_next = 1'b0;
    btn_clr = 1'b0;
    repeat (DEB + 4) step();
  endtask
  task automatic m_zero();
    m_phase = 0;
    m_valid = 0;
    m_a = '0;
    m_b = '0;
    m_sel = '0;
    m_res = '0;
    m_flags = '0;
    m_to = 0;
    m_mm = 0;
  endtask
  task automatic m_clr();
    m_phase = 0;
    m_valid = 0;
    m_res = '0;
    m_flags = '0;
    m_to = 0;
    m_mm = 0;
  endtask
  task automatic nxt_press(input bit hold);
    bit seen = 0;
    btn_next = 1'b1;
    for (int i = 0; i < DEB + 10 && !seen; i++) begin
      step();
      seen = int'(phase) != m_phase;
    end
    chk("nxt_event", 32'(seen), 32'd1);
    case (m_phase)
      0: begin m_a = sw; m_phase = 1; end
      1: begin m_b = sw; m_phase = 2; end
      2: begin m_sel = sw[2:0]; m_phase = 3; m_valid = 1; end
      5: m_phase = 0;
      default: ;
    endcase
    chk_all();
    if (!hold) rel();
  endtask
  task automatic clr_press();
    btn_clr = 1'b1;
    repeat (DEB + 6) step();
    m_clr();
    chk_all();
    rel();
  endtask
  // mode 0: ready immediately, 1: ready after k WAIT cycles, 2: never ready
  task automatic run_cmd(input int a, input int b, input int op, input int mode, input int k, input int outv_in);
    logic [4:0] e;
    int outv;
    e = ref_alu(a, b, op);
    outv = outv_in < 0 ? int'(e) : outv_in;
    sw = 4'(a);
    nxt_press(0);
    sw = 4'(b);
    nxt_press(0);
    alu_out = 5'(outv);
    alu_flags = 4'($urandom);
    alu_ready = mode == 0;
    sw = {1'($urandom), 3'(op)};
    nxt_press(1);
    step();
    m_phase = 4;
    chk_all();
    if (mode == 1) begin
      repeat (k) begin step(); chk_all(); end
      alu_ready = 1'b1;
    end
    if (mode == 2) begin
      repeat (TO - 1) begin step(); chk_all(); end
      step();
      m_phase = 5;
      m_valid = 0;
      m_to = 1;
      chk_all();
    end else begin
      step();
      m_phase = 5;
      m_valid = 0;
      m_to = 0;
      m_res = 5'(outv);
      m_flags = alu_flags;
      if (SELF && 5'(outv) != e) m_mm = 1;
      chk_all();
    end
    alu_ready = 1'b0;
    rel();
  endtask
  initial begin
    m_zero();
    repeat (2) step();
    chk_all();
    rst_n = 1'b1;
    step();
    chk_all();
    run_cmd(3, 4, 0, 0, 0, -1);
    chk("basic_res", 32'(res), 32'h07);
    btn_next = 1'b1;
    repeat (DEB - 1) step();
    btn_next = 1'b0;
    repeat (DEB + 10) step();
    chk("glitch_phase", 32'(phase), 32'd5);
    btn_next = 1'b1;
    repeat (100) step();
    m_phase = 0;
    chk_all();
    rel();
    chk_all();
    run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1, 2, 0, -1);
    nxt_press(0);
    sw = 4'd9;
    nxt_press(0);
    sw = 4'd6;
    btn_next = 1'b1;
    btn_clr = 1'b1;
    repeat (DEB + 8) step();
    m_clr();
    chk_all();
    rel();
    chk_all();
    run_cmd(5, 5, 7, 0, 0, 0);
    nxt_press(0);
    run_cmd(5, 5, 7, 0, 0, 1);
    clr_press();
    for (int n = 0; n < 10; n++) begin
      int a, b, op, e;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      op = int'($urandom_range(0, 7));
      e = int'(ref_alu(a, b, op));
      run_cmd(a, b, op, int'($urandom_range(0, 2)), int'($urandom_range(1, TO - 1)),
              $urandom_range(0, 3) == 0 ? (e + int'($urandom_range(1, 31))) % 32 : -1);
      nxt_press(0);
    end
    sw = 4'd1;
    nxt_press(0);
    sw = 4'd2;
    nxt_press(0);
    sw = 4'd3;
    alu_ready = 1'b0;
    nxt_press(1);
    repeat (2) step();
    btn_next = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    m_zero();
    chk_all();
    rst_n = 1'b1;
    repeat (DEB + 4) step();
    chk_all();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
